// File: rtl/iterative_shift_unit_pkg.sv
// Shared definitions for the iterative RV32I shift unit.
// - state_e : FSM state encoding (idle / shifting / result held)
// - Op*     : operation encoding {funct3_2, funct7_5}; left shifts normalise to OpSll
// - clog2   : ceiling log2, used to size the shift-amount and step-amount fields
package iterative_shift_unit_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // funct7_5 is a don't-care on a left shift; the unit stores it as 0.
  localparam logic [1:0] OpSll = 2'b00;
  localparam logic [1:0] OpSrl = 2'b10;
  localparam logic [1:0] OpSra = 2'b11;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/iterative_shift_unit_if.sv
// Request/result bundle between pipeline control (master) and the shift unit (slave).
// Request : En, Ready_In, Src1, Src2, funct3_2, funct7_5, Flush
// Result  : Result, Result_Valid, Result_Ready
interface iterative_shift_unit_if #(
  parameter int unsigned XLEN = 32
);

  logic            En;
  logic            Ready_In;
  logic [XLEN-1:0] Src1;
  logic [XLEN-1:0] Src2;
  logic            funct3_2;
  logic            funct7_5;
  logic            Flush;
  logic [XLEN-1:0] Result;
  logic            Result_Valid;
  logic            Result_Ready;

  modport master (
    output En, Src1, Src2, funct3_2, funct7_5, Flush, Result_Ready,
    input  Ready_In, Result, Result_Valid
  );

  modport slave (
    input  En, Src1, Src2, funct3_2, funct7_5, Flush, Result_Ready,
    output Ready_In, Result, Result_Valid
  );

endinterface

// File: rtl/iterative_shift_unit_shift_step.sv
// Combinational shifter by 0..STEP bit positions.
// Ports:
//   data_i  : value to shift
//   amt_i   : shift amount, 0..STEP
//   right_i : 1 = shift right, 0 = shift left (left always fills 0)
//   fill_i  : bit shifted in from the top on a right shift
//   data_o  : shifted value
module iterative_shift_unit_shift_step
  import iterative_shift_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4,
  parameter int unsigned AmtW = clog2(STEP) + 1
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [AmtW-1:0] amt_i,
  input  logic            right_i,
  input  logic            fill_i,
  output logic [XLEN-1:0] data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < int'(XLEN); i++) begin
      if (right_i) begin
        data_o[i] = (i + int'(amt_i) < int'(XLEN)) ? data_i[i + int'(amt_i)] : fill_i;
      end else begin
        data_o[i] = (i >= int'(amt_i)) ? data_i[i - int'(amt_i)] : 1'b0;
      end
    end
  end

endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-cycle RV32I shifter (SLL/SRL/SRA) that moves at most STEP bits per cycle.
// Ports:
//   CLK : system clock, rising edge
//   RST : asynchronous active-high reset
//   bus : slave side of iterative_shift_unit_if
//         En/Ready_In start handshake, Src1/Src2/funct3_2/funct7_5 operands,
//         Flush abort, Result/Result_Valid/Result_Ready result handshake.
// STEP must be a power of two in 1..XLEN.
module iterative_shift_unit
  import iterative_shift_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 4
) (
  input logic                 CLK,
  input logic                 RST,
  iterative_shift_unit_if.slave bus
);

  localparam int unsigned ShW  = clog2(XLEN);
  localparam int unsigned AmtW = clog2(STEP) + 1;

  state_e          state_q;
  logic [XLEN-1:0] data_q;
  logic [ShW-1:0]  rem_q;
  logic [1:0]      op_q;
  logic [XLEN-1:0] result_q;
  logic            valid_q;
  logic            ready_q;

  logic [AmtW-1:0] k_amt;
  logic [ShW-1:0]  rem_next;
  logic [ShW-1:0]  shamt_in;
  logic            fill;
  logic [XLEN-1:0] step_data;

  // Only the low log2(XLEN) bits of Src2 carry the shift amount.
  logic unused_src2;
  assign unused_src2 = ^bus.Src2[XLEN-1:ShW];

  assign shamt_in = bus.Src2[ShW-1:0];

  // An arithmetic shift keeps the sign in data_q's MSB on every step, so that bit is
  // always the captured Src1 sign.
  assign fill = (op_q == OpSra) & data_q[XLEN-1];

  always_comb begin
    if (int'(rem_q) < int'(STEP)) begin
      k_amt = AmtW'(rem_q);
    end else begin
      k_amt = AmtW'(STEP);
    end
    rem_next = rem_q - ShW'(k_amt);
  end

  iterative_shift_unit_shift_step #(
    .XLEN (XLEN),
    .STEP (STEP),
    .AmtW (AmtW)
  ) u_shift_step (
    .data_i  (data_q),
    .amt_i   (k_amt),
    .right_i (op_q[1]),
    .fill_i  (fill),
    .data_o  (step_data)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      data_q   <= '0;
      rem_q    <= '0;
      op_q     <= OpSll;
      result_q <= '0;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
    end else if (bus.Flush) begin
      // Abort wins over accept, completion and the result handshake.
      state_q <= StIdle;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.En) begin
            data_q  <= bus.Src1;
            rem_q   <= shamt_in;
            op_q    <= {bus.funct3_2, bus.funct3_2 & bus.funct7_5};
            ready_q <= 1'b0;
            if (shamt_in == '0) begin
              state_q  <= StDone;
              valid_q  <= 1'b1;
              result_q <= bus.Src1;
            end else begin
              state_q <= StShift;
            end
          end
        end
        StShift: begin
          data_q <= step_data;
          rem_q  <= rem_next;
          if (rem_next == '0) begin
            state_q  <= StDone;
            valid_q  <= 1'b1;
            result_q <= step_data;
          end
        end
        StDone: begin
          // En is ignored here even if it arrives with Result_Ready.
          if (bus.Result_Ready) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.Ready_In     = ready_q;
  assign bus.Result_Valid = valid_q;
  assign bus.Result       = result_q;

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Self-checking bench for iterative_shift_unit: directed vector table, hand-written
// abort/reset/handshake sequences and a random run against a <<, >>, >>> model.
module tb_iterative_shift_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned STEP = 4;

  logic clk;
  logic rst;

  int total;
  int bad;

  iterative_shift_unit_if #(.XLEN(XLEN)) bus ();

  iterative_shift_unit #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] s1;
    logic [31:0] s2;
    logic        f3;
    logic        f7;
    logic [31:0] exp;
    int          lat;
    int          bp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] s1, input logic [31:0] s2,
                                            input logic f3, input logic f7);
    int sh;
    sh = int'(s2[4:0]);
    if (!f3) return s1 << sh;
    if (f7) return $signed(s1) >>> sh;
    return s1 >> sh;
  endfunction

  function automatic int ref_lat(input logic [31:0] s2);
    return 1 + (int'(s2[4:0]) + int'(STEP) - 1) / int'(STEP);
  endfunction

  task automatic quiet_inputs();
    bus.En           = 1'b0;
    bus.Src1         = '0;
    bus.Src2         = '0;
    bus.funct3_2     = 1'b0;
    bus.funct7_5     = 1'b0;
    bus.Flush        = 1'b0;
    bus.Result_Ready = 1'b0;
  endtask

  // Issues one request from a post-edge point, checks latency, holds the result for bp
  // cycles of backpressure, then completes the handshake. poke_en keeps En high while busy.
  task automatic run_op(input string tag, input logic [31:0] s1, input logic [31:0] s2,
                        input logic f3, input logic f7, input logic [31:0] exp,
                        input int exp_lat, input int bp, input bit poke_en);
    int lat;
    check({tag, "_ready_before"}, 32'(bus.Ready_In), 32'd1);
    bus.En       = 1'b1;
    bus.Src1     = s1;
    bus.Src2     = s2;
    bus.funct3_2 = f3;
    bus.funct7_5 = f7;
    @(posedge clk);
    #1;
    bus.En       = poke_en;
    bus.Src1     = ~s1;
    bus.Src2     = s2 ^ 32'h15;
    bus.funct3_2 = ~f3;
    bus.funct7_5 = ~f7;
    lat = 1;
    while (bus.Result_Valid !== 1'b1 && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_result"}, bus.Result, exp);
    check({tag, "_ready_busy"}, 32'(bus.Ready_In), 32'd0);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_bp_valid"}, 32'(bus.Result_Valid), 32'd1);
      check({tag, "_bp_result"}, bus.Result, exp);
    end
    bus.Result_Ready = 1'b1;
    @(posedge clk);
    #1;
    bus.Result_Ready = 1'b0;
    bus.En           = 1'b0;
    check({tag, "_valid_after"}, 32'(bus.Result_Valid), 32'd0);
    check({tag, "_ready_after"}, 32'(bus.Ready_In), 32'd1);
    check({tag, "_result_held"}, bus.Result, exp);
  endtask

  // Overall time bound so the run can never hang.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit saw_valid;
    logic [31:0] rs1, rs2;
    logic        rf3, rf7;

    total = 0;
    bad   = 0;
    quiet_inputs();

    //             s1            s2           f3    f7    exp           lat bp
    vecs[0] = '{32'd50,       32'd4,        1'b0, 1'b0, 32'd800,       2, 0};
    vecs[1] = '{32'hABCDFFFF, 32'd5,        1'b1, 1'b0, 32'h055E6FFF,  3, 0};
    vecs[2] = '{32'hABCDFFFF, 32'd3,        1'b1, 1'b1, 32'hF579BFFF,  2, 0};
    vecs[3] = '{32'h80000000, 32'd31,       1'b1, 1'b1, 32'hFFFFFFFF,  9, 0};
    vecs[4] = '{32'h12345678, 32'h20,       1'b0, 1'b0, 32'h12345678,  1, 0};
    vecs[5] = '{32'hCAFEF00D, 32'h20,       1'b1, 1'b1, 32'hCAFEF00D,  1, 5};
    vecs[6] = '{32'h00000001, 32'd31,       1'b0, 1'b0, 32'h80000000,  9, 2};
    vecs[7] = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000001,  9, 0};
    vecs[8] = '{32'h0000000F, 32'd8,        1'b0, 1'b1, 32'h00000F00,  3, 1};
    vecs[9] = '{32'h7FFFFFF0, 32'd4,        1'b1, 1'b1, 32'h07FFFFFF,  2, 5};

    // Reset state, sampled while reset is held across an edge.
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("reset_ready", 32'(bus.Ready_In), 32'd1);
    check("reset_valid", 32'(bus.Result_Valid), 32'd0);
    check("reset_result", bus.Result, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_no_valid", 32'(bus.Result_Valid), 32'd0);

    for (int v = 0; v < 10; v++) begin
      run_op($sformatf("vec%0d", v), vecs[v].s1, vecs[v].s2, vecs[v].f3, vecs[v].f7,
             vecs[v].exp, vecs[v].lat, vecs[v].bp, 1'b0);
    end

    // En held high through SHIFT and DONE, including the Result_Ready edge.
    run_op("en_ignored", 32'hABCDFFFF, 32'd5, 1'b1, 1'b0, 32'h055E6FFF, 3, 2, 1'b1);
    saw_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.Result_Valid) saw_valid = 1'b1;
    end
    check("en_ignored_no_extra_result", 32'(saw_valid), 32'd0);

    // Flush two cycles into a shamt=31 operation.
    bus.En   = 1'b1;
    bus.Src1 = 32'h80000000;
    bus.Src2 = 32'd31;
    bus.funct3_2 = 1'b1;
    bus.funct7_5 = 1'b1;
    @(posedge clk);
    #1;
    bus.En = 1'b0;
    @(posedge clk);
    #1;
    bus.Flush = 1'b1;
    @(posedge clk);
    #1;
    bus.Flush = 1'b0;
    check("flush_shift_ready", 32'(bus.Ready_In), 32'd1);
    check("flush_shift_valid", 32'(bus.Result_Valid), 32'd0);
    saw_valid = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.Result_Valid) saw_valid = 1'b1;
    end
    check("flush_shift_no_result", 32'(saw_valid), 32'd0);

    // Flush beats Result_Ready in DONE; Result keeps its value.
    bus.En   = 1'b1;
    bus.Src1 = 32'h5A5A1234;
    bus.Src2 = 32'd0;
    bus.funct3_2 = 1'b0;
    @(posedge clk);
    #1;
    bus.En = 1'b0;
    check("flush_done_valid_before", 32'(bus.Result_Valid), 32'd1);
    bus.Flush        = 1'b1;
    bus.Result_Ready = 1'b1;
    @(posedge clk);
    #1;
    bus.Flush        = 1'b0;
    bus.Result_Ready = 1'b0;
    check("flush_done_valid", 32'(bus.Result_Valid), 32'd0);
    check("flush_done_ready", 32'(bus.Ready_In), 32'd1);
    check("flush_done_result_held", bus.Result, 32'h5A5A1234);

    // Flush and En together in IDLE: request must not be accepted.
    bus.En    = 1'b1;
    bus.Flush = 1'b1;
    bus.Src2  = 32'd0;
    @(posedge clk);
    #1;
    bus.En    = 1'b0;
    bus.Flush = 1'b0;
    check("flush_idle_ready", 32'(bus.Ready_In), 32'd1);
    saw_valid = bus.Result_Valid;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.Result_Valid) saw_valid = 1'b1;
    end
    check("flush_idle_no_result", 32'(saw_valid), 32'd0);

    // Asynchronous reset between edges in the middle of SHIFT.
    bus.En   = 1'b1;
    bus.Src1 = 32'h80000000;
    bus.Src2 = 32'd31;
    bus.funct3_2 = 1'b1;
    bus.funct7_5 = 1'b1;
    @(posedge clk);
    #1;
    bus.En = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_ready", 32'(bus.Ready_In), 32'd1);
    check("async_rst_valid", 32'(bus.Result_Valid), 32'd0);
    check("async_rst_result", bus.Result, 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.Result_Valid) saw_valid = 1'b1;
    end
    check("async_rst_no_result", 32'(saw_valid), 32'd0);
    run_op("post_reset", 32'd50, 32'd4, 1'b0, 1'b0, 32'd800, 2, 0, 1'b0);

    // Random operations with random backpressure and idle gaps.
    for (int n = 0; n < 1000; n++) begin
      rs1 = $urandom;
      rs2 = $urandom;
      rf3 = 1'($urandom_range(0, 1));
      rf7 = 1'($urandom_range(0, 1));
      run_op("rand", rs1, rs2, rf3, rf7, ref_shift(rs1, rs2, rf3, rf7), ref_lat(rs2),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 1)) @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
